// File: rtl/xor_gate.sv
// Bitwise two-operand XOR primitive: zero-latency combinational result plus a
// clocked observation path (registered result, XOR accumulator, parity, nonzero count).
module xor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] a_xor_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] a_xor_b_q,
  output logic [WIDTH-1:0] acc,
  output logic             parity,
  output logic [CNT_W-1:0] nz_cnt
);

  logic             nonzero;
  logic [CNT_W-1:0] cnt_inc;

  assign a_xor_b = a ^ b;
  assign nonzero = |a_xor_b;

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (nz_cnt == '1) ? nz_cnt : nz_cnt + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_xor_b_q <= '0;
      parity    <= 1'b0;
      acc       <= '0;
      nz_cnt    <= '0;
    end else begin
      if (en) begin
        a_xor_b_q <= a_xor_b;
        parity    <= ^a_xor_b;
      end
      // Clear wins over accumulate, but an enabled operand is loaded in the same edge.
      if (clr) begin
        acc    <= en ? a_xor_b : '0;
        nz_cnt <= (en && nonzero) ? CNT_W'(1) : '0;
      end else if (en) begin
        acc <= acc ^ a_xor_b;
        if (nonzero) nz_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: a WIDTH=1 instance and a WIDTH=4/CNT_W=2
// instance, checked every cycle against an arithmetic model plus literal vectors.
module tb_xor_gate;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       cmp_on = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0;
  logic       x1, q1, acc1, par1;
  logic [7:0] cnt1;

  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic [3:0] x4, q4, acc4;
  logic       par4;
  logic [1:0] cnt4;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state, plain integers.
  int m1_q, m1_acc, m1_par, m1_cnt;
  int m4_q, m4_acc, m4_par, m4_cnt;

  always #5 clk = clk_run ? ~clk : clk;

  xor_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a_xor_b(x1), .a(a1), .b(b1), .en(en), .clr(clr),
    .a_xor_b_q(q1), .acc(acc1), .parity(par1), .nz_cnt(cnt1)
  );

  xor_gate #(.WIDTH(4), .CNT_W(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a_xor_b(x4), .a(a4), .b(b4), .en(en), .clr(clr),
    .a_xor_b_q(q4), .acc(acc4), .parity(par4), .nz_cnt(cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the register-transfer rules expressed with integer arithmetic.
  always @(posedge clk or negedge rst_n) begin
    int r1, r4;
    if (!rst_n) begin
      m1_q = 0; m1_acc = 0; m1_par = 0; m1_cnt = 0;
      m4_q = 0; m4_acc = 0; m4_par = 0; m4_cnt = 0;
    end else begin
      r1 = int'(a1) ^ int'(b1);
      r4 = int'(a4) ^ int'(b4);
      if (en) begin
        m1_q = r1; m1_par = $countones(r1) % 2;
        m4_q = r4; m4_par = $countones(r4) % 2;
      end
      if (clr) begin
        m1_acc = en ? r1 : 0; m1_cnt = (en && r1 != 0) ? 1 : 0;
        m4_acc = en ? r4 : 0; m4_cnt = (en && r4 != 0) ? 1 : 0;
      end else if (en) begin
        m1_acc = m1_acc ^ r1; if (r1 != 0 && m1_cnt < 255) m1_cnt++;
        m4_acc = m4_acc ^ r4; if (r4 != 0 && m4_cnt < 3) m4_cnt++;
      end
    end
  end

  // Compare process: every falling edge, well away from the capturing edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("w1.a_xor_b", 32'(x1), 32'(a1 ^ b1));
      check("w1.q", 32'(q1), m1_q);
      check("w1.acc", 32'(acc1), m1_acc);
      check("w1.parity", 32'(par1), m1_par);
      check("w1.nz_cnt", 32'(cnt1), m1_cnt);
      check("w4.a_xor_b", 32'(x4), 32'(a4 ^ b4));
      check("w4.q", 32'(q4), m4_q);
      check("w4.acc", 32'(acc4), m4_acc);
      check("w4.parity", 32'(par4), m4_par);
      check("w4.nz_cnt", 32'(cnt4), m4_cnt);
    end
  end

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] acc_exp [3];
  logic [3:0] va [3];
  int         cnt_exp [3];
  int         sat_exp [5];

  initial begin
    // Combinational truth table with the clock stopped.
    logic [1:0] tt_in [4];
    logic       tt_out [4];
    tt_in[0] = 2'b00; tt_in[1] = 2'b10; tt_in[2] = 2'b01; tt_in[3] = 2'b11;
    tt_out[0] = 1'b0; tt_out[1] = 1'b1; tt_out[2] = 1'b1; tt_out[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1]; b1 = tt_in[i][0];
      #10;
      check("truth_table", 32'(x1), 32'(tt_out[i]));
    end

    // Reset held with clock running and en=1, a=1, b=0.
    a1 = 1'b1; b1 = 1'b0; en = 1'b1;
    clk_run = 1'b1; cmp_on = 1'b1;
    repeat (3) edge_then_settle();
    check("rst_hold.q", 32'(q1), 0);
    check("rst_hold.nz_cnt", 32'(cnt1), 0);
    check("rst_hold.a_xor_b", 32'(x1), 1);
    #1 rst_n = 1'b1;
    edge_then_settle();
    check("post_rst.q", 32'(q1), 1);
    check("post_rst.parity", 32'(par1), 1);
    check("post_rst.nz_cnt", 32'(cnt1), 1);

    // Accumulate on the WIDTH=4 instance.
    a1 = 1'b0;
    va[0] = 4'h3; va[1] = 4'h5; va[2] = 4'hF;
    acc_exp[0] = 4'h3; acc_exp[1] = 4'h6; acc_exp[2] = 4'h6;
    cnt_exp[0] = 1; cnt_exp[1] = 2; cnt_exp[2] = 2;
    for (int i = 0; i < 3; i++) begin
      a4 = va[i]; b4 = (i == 2) ? 4'hF : 4'h0;
      edge_then_settle();
      check("accum.acc", 32'(acc4), 32'(acc_exp[i]));
      check("accum.nz_cnt", 32'(cnt4), cnt_exp[i]);
      check("accum.parity", 32'(par4), 0);
    end

    // Simultaneous clear and load, then clear alone (registered result holds).
    clr = 1'b1; a4 = 4'h9; b4 = 4'h0;
    edge_then_settle();
    check("clr_en.acc", 32'(acc4), 32'h9);
    check("clr_en.nz_cnt", 32'(cnt4), 1);
    en = 1'b0; a4 = 4'h6;
    edge_then_settle();
    check("clr_only.acc", 32'(acc4), 0);
    check("clr_only.nz_cnt", 32'(cnt4), 0);
    check("clr_only.q_hold", 32'(q4), 32'h9);

    // Saturation at CNT_W=2.
    clr = 1'b0; en = 1'b1; a4 = 4'h1; b4 = 4'h0;
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    for (int i = 0; i < 5; i++) begin
      edge_then_settle();
      check("sat.nz_cnt", 32'(cnt4), sat_exp[i]);
    end
    check("sat.acc_nonzero", 32'(acc4), 32'h1);

    // Asynchronous reset between edges while acc is nonzero.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.acc", 32'(acc4), 0);
    check("async_rst.q", 32'(q4), 0);
    check("async_rst.parity", 32'(par4), 0);
    check("async_rst.nz_cnt", 32'(cnt4), 0);
    repeat (2) edge_then_settle();
    #1 rst_n = 1'b1;
    repeat (3) edge_then_settle();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
